reorder_buffer: RTL and testbench

Circular reorder buffer for the out-of-order backend. It allocates one entry per cycle to the instruction issuer and returns the alias ID. It captures results broadcast on the common data bus (CDB) and answers CDB listen queries from the issuer, forwarding data for completed entries. It retires completed entries in program order to the architectural register file and register alias table (RAT), and is cleared by a pipeline flush.

---
 rtl/reorder_buffer.sv | 135 +++++++++++++
 tb/tb_reorder_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates one entry per cycle, captures CDB results,
// forwards completed results to listen ports and retires in program order.
module reorder_buffer #(
    parameter int ROB_ENTRY       = 4,
    parameter int ARCH_ENTRY      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LSN_PORTS       = 4,
    parameter int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY),
    parameter int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY)
) (
    input  logic                                CLK,
    input  logic                                RSTN,
    input  logic                                rob_request,
    input  logic [ARCH_ENTRY_LOG2-1:0]          rob_arch_id,
    output logic                                rob_grant,
    output logic [ROB_ENTRY_LOG2-1:0]           rob_alias_id,
    input  logic                                cdb_valid,
    input  logic [ROB_ENTRY_LOG2-1:0]           cdb_alias,
    input  logic [DATA_WIDTH-1:0]               cdb_data,
    input  logic [LSN_PORTS-1:0]                lsn_request,
    input  logic [LSN_PORTS*ROB_ENTRY_LOG2-1:0] lsn_id,
    output logic [LSN_PORTS-1:0]                lsn_hit,
    output logic [LSN_PORTS*DATA_WIDTH-1:0]     lsn_data,
    output logic                                commit_valid,
    output logic [ARCH_ENTRY_LOG2-1:0]          commit_arch_id,
    output logic [ROB_ENTRY_LOG2-1:0]           commit_alias,
    output logic [DATA_WIDTH-1:0]               commit_data,
    input  logic                                flush
);

    localparam int CNT_W = ROB_ENTRY_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ROB_ENTRY);

    logic [ROB_ENTRY-1:0]       valid_q, valid_d;
    logic [ROB_ENTRY-1:0]       done_q, done_d;
    logic [ARCH_ENTRY_LOG2-1:0] arch_q [ROB_ENTRY];
    logic [ARCH_ENTRY_LOG2-1:0] arch_d [ROB_ENTRY];
    logic [DATA_WIDTH-1:0]      data_q [ROB_ENTRY];
    logic [DATA_WIDTH-1:0]      data_d [ROB_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0]  head_q, head_d;
    logic [ROB_ENTRY_LOG2-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;

    logic alloc;
    logic commit;

    // Grant ignores a same-cycle commit so a full buffer stays closed for one cycle.
    assign rob_grant      = (count_q != FULL_COUNT) & ~flush;
    assign rob_alias_id   = tail_q;
    assign alloc          = rob_request & rob_grant;

    assign commit_valid   = valid_q[head_q] & done_q[head_q];
    assign commit_arch_id = arch_q[head_q];
    assign commit_alias   = head_q;
    assign commit_data    = data_q[head_q];
    assign commit         = commit_valid;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        arch_d  = arch_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // The allocating entry is still invalid here, so a CDB hit on it is dropped.
        if (cdb_valid && valid_q[cdb_alias]) begin
            done_d[cdb_alias] = 1'b1;
            data_d[cdb_alias] = cdb_data;
        end

        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            arch_d[tail_q]  = rob_arch_id;
            tail_d          = tail_q + 1'b1;
        end

        if (commit) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        if (alloc && !commit) begin
            count_d = count_q + 1'b1;
        end else if (commit && !alloc) begin
            count_d = count_q - 1'b1;
        end

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_ENTRY; i++) begin
                arch_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            arch_q  <= arch_d;
            data_q  <= data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LSN_PORTS; gi++) begin : g_lsn
            logic [ROB_ENTRY_LOG2-1:0] id;
            logic                      fwd;

            assign id  = lsn_id[gi*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
            assign fwd = cdb_valid & (cdb_alias == id);
            assign lsn_hit[gi] = lsn_request[gi] & valid_q[id] & (done_q[id] | fwd);
            assign lsn_data[gi*DATA_WIDTH +: DATA_WIDTH] = fwd ? cdb_data : data_q[id];
        end
    endgenerate

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: fill, out-of-order completion,
// forwarding, full-with-commit, flush, wrap-around and asynchronous reset.
module tb_reorder_buffer;

    logic         CLK;
    logic         RSTN;
    logic         rob_request;
    logic [4:0]   rob_arch_id;
    logic         rob_grant;
    logic [1:0]   rob_alias_id;
    logic         cdb_valid;
    logic [1:0]   cdb_alias;
    logic [31:0]  cdb_data;
    logic [3:0]   lsn_request;
    logic [7:0]   lsn_id;
    logic [3:0]   lsn_hit;
    logic [127:0] lsn_data;
    logic         commit_valid;
    logic [4:0]   commit_arch_id;
    logic [1:0]   commit_alias;
    logic [31:0]  commit_data;
    logic         flush;

    int check_count = 0;
    int error_count = 0;

    reorder_buffer dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .rob_request    (rob_request),
        .rob_arch_id    (rob_arch_id),
        .rob_grant      (rob_grant),
        .rob_alias_id   (rob_alias_id),
        .cdb_valid      (cdb_valid),
        .cdb_alias      (cdb_alias),
        .cdb_data       (cdb_data),
        .lsn_request    (lsn_request),
        .lsn_id         (lsn_id),
        .lsn_hit        (lsn_hit),
        .lsn_data       (lsn_data),
        .commit_valid   (commit_valid),
        .commit_arch_id (commit_arch_id),
        .commit_alias   (commit_alias),
        .commit_data    (commit_data),
        .flush          (flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        rob_request = 1'b0;
        rob_arch_id = '0;
        cdb_valid   = 1'b0;
        cdb_alias   = '0;
        cdb_data    = '0;
        lsn_request = '0;
        lsn_id      = '0;
        flush       = 1'b0;
    endtask

    task automatic check_commit(input string tag, input logic [1:0] alias_e,
                                input logic [4:0] arch_e, input logic [31:0] data_e);
        check_val({tag, "_valid"}, 64'(commit_valid), 64'd1);
        check_val({tag, "_alias"}, 64'(commit_alias), 64'(alias_e));
        check_val({tag, "_arch"},  64'(commit_arch_id), 64'(arch_e));
        check_val({tag, "_data"},  64'(commit_data), 64'(data_e));
    endtask

    initial begin
        idle();
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        // Reset values, with every listen port querying.
        lsn_request = 4'hF;
        lsn_id      = 8'b11_10_01_00;
        #1;
        check_val("rst_grant",      64'(rob_grant), 64'd1);
        check_val("rst_alias",      64'(rob_alias_id), 64'd0);
        check_val("rst_cvalid",     64'(commit_valid), 64'd0);
        check_val("rst_carch",      64'(commit_arch_id), 64'd0);
        check_val("rst_calias",     64'(commit_alias), 64'd0);
        check_val("rst_cdata",      64'(commit_data), 64'd0);
        check_val("rst_lsn_hit",    64'(lsn_hit), 64'd0);
        check_val("rst_lsn_data",   lsn_data[63:0], 64'd0);
        idle();
        RSTN = 1'b1;
        tick();

        // Fill: arch 5..8 get aliases 0..3.
        for (int i = 0; i < 4; i++) begin
            rob_request = 1'b1;
            rob_arch_id = 5'(5 + i);
            #1;
            check_val($sformatf("fill%0d_grant", i), 64'(rob_grant), 64'd1);
            check_val($sformatf("fill%0d_alias", i), 64'(rob_alias_id), 64'(i));
            tick();
        end
        rob_request = 1'b1;
        rob_arch_id = 5'd9;
        #1;
        check_val("full_grant", 64'(rob_grant), 64'd0);
        tick();
        idle();
        #1;
        check_val("full_hold_grant", 64'(rob_grant), 64'd0);
        check_val("full_hold_alias", 64'(rob_alias_id), 64'd0);
        check_val("full_no_commit",  64'(commit_valid), 64'd0);

        // Out-of-order completion: alias 2 first, then alias 0.
        cdb_valid = 1'b1; cdb_alias = 2'd2; cdb_data = 32'hAA;
        tick();
        cdb_alias = 2'd0; cdb_data = 32'h11;
        #1;
        check_val("ooo_no_commit", 64'(commit_valid), 64'd0);
        tick();
        idle();
        #1;
        check_commit("commit0", 2'd0, 5'd5, 32'h11);
        check_val("fullcommit_grant", 64'(rob_grant), 64'd0);
        tick();
        check_val("after_commit_grant", 64'(rob_grant), 64'd1);
        check_val("after_commit_alias", 64'(rob_alias_id), 64'd0);
        check_val("wait_alias1",        64'(commit_valid), 64'd0);
        tick();
        check_val("still_wait_alias1",  64'(commit_valid), 64'd0);

        // Same-cycle forwarding on port 3 (entry 1) plus stored data on port 0 (entry 2).
        lsn_request = 4'b1001;
        lsn_id      = 8'b01_00_00_10;
        cdb_valid = 1'b1; cdb_alias = 2'd1; cdb_data = 32'hDEAD;
        #1;
        check_val("fwd_hit",    64'(lsn_hit), 64'b1001);
        check_val("fwd_data3",  64'(lsn_data[127:96]), 64'hDEAD);
        check_val("fwd_data0",  64'(lsn_data[31:0]), 64'hAA);
        check_val("fwd_no_commit", 64'(commit_valid), 64'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        check_val("stored_hit",  64'(lsn_hit), 64'b1001);
        check_val("stored_data3", 64'(lsn_data[127:96]), 64'hDEAD);
        check_commit("commit1", 2'd1, 5'd6, 32'hDEAD);
        tick();
        check_commit("commit2", 2'd2, 5'd7, 32'hAA);
        tick();
        check_val("head3_pending", 64'(commit_valid), 64'd0);
        // Entry 1 has retired: a matching CDB must not produce a hit.
        lsn_request = 4'b1000;
        lsn_id      = 8'b01_00_00_00;
        cdb_valid = 1'b1; cdb_alias = 2'd1; cdb_data = 32'hBEEF;
        #1;
        check_val("nohit_invalid", 64'(lsn_hit), 64'd0);
        tick();
        idle();

        // Flush with entries 3, 0, 1 valid and entry 0 done.
        rob_request = 1'b1; rob_arch_id = 5'd10;
        #1;
        check_val("pre_flush_alias0", 64'(rob_alias_id), 64'd0);
        tick();
        rob_arch_id = 5'd11;
        #1;
        check_val("pre_flush_alias1", 64'(rob_alias_id), 64'd1);
        tick();
        idle();
        cdb_valid = 1'b1; cdb_alias = 2'd0; cdb_data = 32'h55;
        tick();
        idle();
        flush = 1'b1;
        #1;
        check_val("flush_grant_low", 64'(rob_grant), 64'd0);
        tick();
        flush = 1'b0;
        lsn_request = 4'hF;
        lsn_id      = 8'b11_01_00_11;
        #1;
        check_val("post_flush_grant",  64'(rob_grant), 64'd1);
        check_val("post_flush_alias",  64'(rob_alias_id), 64'd0);
        check_val("post_flush_cvalid", 64'(commit_valid), 64'd0);
        check_val("post_flush_lsn",    64'(lsn_hit), 64'd0);
        idle();

        // Wrap: six sequential allocate/complete/retire rounds.
        for (int i = 0; i < 6; i++) begin
            rob_request = 1'b1;
            rob_arch_id = 5'(i + 1);
            #1;
            check_val($sformatf("wrap%0d_alias", i), 64'(rob_alias_id), 64'(i % 4));
            tick();
            idle();
            cdb_valid = 1'b1; cdb_alias = 2'(i % 4); cdb_data = 32'(32'h100 + i);
            tick();
            idle();
            check_commit($sformatf("wrap%0d", i), 2'(i % 4), 5'(i + 1), 32'(32'h100 + i));
            tick();
        end
        check_val("wrap_empty", 64'(commit_valid), 64'd0);

        // Asynchronous reset mid-cycle with a committable head.
        rob_request = 1'b1; rob_arch_id = 5'd20;
        tick();
        idle();
        cdb_valid = 1'b1; cdb_alias = 2'd2; cdb_data = 32'h77;
        tick();
        idle();
        check_val("pre_arst_cvalid", 64'(commit_valid), 64'd1);
        #1;
        RSTN = 1'b0;
        #1;
        check_val("arst_cvalid", 64'(commit_valid), 64'd0);
        check_val("arst_alias",  64'(rob_alias_id), 64'd0);
        check_val("arst_cdata",  64'(commit_data), 64'd0);
        check_val("arst_grant",  64'(rob_grant), 64'd1);
        tick();
        RSTN = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
